// File: rtl/conv1_c_dump_reader_if.sv
// Bus bundle for the conv1 C dump reader.
// It carries the accumulator BRAM read port and the output beat stream.
// The master side is the reader; the slave side is the BRAM plus the downstream consumer.
interface conv1_c_dump_reader_if #(
    parameter int ACC_W  = 32,
    parameter int ADDR_W = 18
);
    logic                     rd_en;
    logic [ADDR_W-1:0]        rd_addr;
    logic signed [ACC_W-1:0]  rd_data;
    logic                     rd_valid;

    logic                     m_valid;
    logic                     m_ready;
    logic signed [ACC_W-1:0]  m_data;
    logic [5:0]               m_co;
    logic [11:0]              m_pix;
    logic                     m_last;

    modport master (
        output rd_en, rd_addr,
        input  rd_data, rd_valid,
        output m_valid, m_data, m_co, m_pix, m_last,
        input  m_ready
    );

    modport slave (
        input  rd_en, rd_addr,
        output rd_data, rd_valid,
        input  m_valid, m_data, m_co, m_pix, m_last,
        output m_ready
    );
endinterface

// File: rtl/conv1_c_dump_reader.sv
// Streams the conv1 C accumulator BRAM out in channel-major order.
// The read order is co outer, pixel inner, and the address is walked with adds only.
// Each read carries its (co, pix, last) tags through a one-deep in-flight stage.
// The tagged data then lands in a 2-entry output FIFO.
// A read is issued only when a FIFO slot is guaranteed for its data.
// ACC_W_P defaults to 32, the backbone accumulator width ACC_W.
module conv1_c_dump_reader #(
    parameter int M_TOTAL = 3136,
    parameter int N_TOTAL = 64,
    parameter int ACC_W_P = 32,
    parameter int ADDR_W  = 18
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    conv1_c_dump_reader_if.master bus
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    localparam logic [5:0]        CO_LAST   = 6'(N_TOTAL - 1);
    localparam logic [11:0]       PIX_LAST  = 12'(M_TOTAL - 1);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(N_TOTAL);

    state_t r_state;
    state_t w_nextState;

    logic [5:0]        r_co;
    logic [11:0]       r_pix;
    logic [ADDR_W-1:0] r_addr;

    logic              r_inflight;
    logic [5:0]        r_ifCo;
    logic [11:0]       r_ifPix;
    logic              r_ifLast;

    logic signed [ACC_W_P-1:0] r_fifoData [2];
    logic [5:0]                r_fifoCo   [2];
    logic [11:0]               r_fifoPix  [2];
    logic                      r_fifoLast [2];
    logic                      r_wrPtr;
    logic                      r_rdPtr;
    logic [1:0]                r_count;

    logic       w_valid;
    logic       w_push;
    logic       w_pop;
    logic       w_lastIssue;
    logic [2:0] w_credit;
    logic       w_rdEn;

    // Stream handshake, and the FIFO/in-flight bookkeeping that gates new reads.
    // The credit counts the pop happening this cycle, which keeps 1 beat/cycle while the FIFO is full.
    assign w_valid     = (r_count != 2'd0);
    assign w_pop       = w_valid && bus.m_ready;
    assign w_push      = r_inflight && bus.rd_valid;
    assign w_lastIssue = (r_co == CO_LAST) && (r_pix == PIX_LAST);
    assign w_credit    = 3'(r_count) + 3'(r_inflight) - 3'(w_pop);

    assign bus.rd_en   = w_rdEn;
    assign bus.rd_addr = r_addr;
    assign bus.m_valid = w_valid;
    assign bus.m_data  = r_fifoData[r_rdPtr];
    assign bus.m_co    = r_fifoCo[r_rdPtr];
    assign bus.m_pix   = r_fifoPix[r_rdPtr];
    assign bus.m_last  = r_fifoLast[r_rdPtr];

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // FSM next-state logic; start is only looked at in IDLE.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start) w_nextState = RUN;
            RUN:     if (w_rdEn && w_lastIssue) w_nextState = DRAIN;
            DRAIN:   if (w_pop && bus.m_last) w_nextState = FIN;
            FIN:     w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // FSM outputs: status flags, plus the read request gated by FIFO credit.
    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        w_rdEn = 1'b0;
        case (r_state)
            RUN: begin
                busy   = 1'b1;
                w_rdEn = (w_credit < 3'd2);
            end
            DRAIN:   busy = 1'b1;
            FIN:     done = 1'b1;
            default: ;
        endcase
    end

    // Channel/pixel counters and the incremental address.
    // The address steps by N_TOTAL per pixel and restarts at co+1 when the pixel count wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_co   <= '0;
            r_pix  <= '0;
            r_addr <= '0;
        end else if (r_state == IDLE && start) begin
            r_co   <= '0;
            r_pix  <= '0;
            r_addr <= '0;
        end else if (w_rdEn) begin
            if (r_pix == PIX_LAST) begin
                r_pix  <= '0;
                r_co   <= r_co + 6'd1;
                r_addr <= ADDR_W'(r_co) + ADDR_W'(1);
            end else begin
                r_pix  <= r_pix + 12'd1;
                r_addr <= r_addr + ADDR_STEP;
            end
        end
    end

    // In-flight stage: records the tags of the read issued last cycle until its data returns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= 1'b0;
            r_ifCo     <= '0;
            r_ifPix    <= '0;
            r_ifLast   <= 1'b0;
        end else begin
            r_inflight <= w_rdEn;
            if (w_rdEn) begin
                r_ifCo   <= r_co;
                r_ifPix  <= r_pix;
                r_ifLast <= w_lastIssue;
            end
        end
    end

    // Two-entry output FIFO; a simultaneous push and pop keeps the occupancy unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_fifoData[i] <= '0;
                r_fifoCo[i]   <= '0;
                r_fifoPix[i]  <= '0;
                r_fifoLast[i] <= 1'b0;
            end
            r_wrPtr <= 1'b0;
            r_rdPtr <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifoData[r_wrPtr] <= bus.rd_data;
                r_fifoCo[r_wrPtr]   <= r_ifCo;
                r_fifoPix[r_wrPtr]  <= r_ifPix;
                r_fifoLast[r_wrPtr] <= r_ifLast;
                r_wrPtr             <= ~r_wrPtr;
            end
            if (w_pop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end

endmodule

// File: tb/tb_conv1_c_dump_reader.sv
// Bench for conv1_c_dump_reader, using a reduced 10-pixel x 4-channel geometry.
// A BRAM model returns (address + offset).
// A negedge monitor pops the expected beat queue on every accepted beat.
// The monitor also tracks stall stability, occupancy and done timing.
module tb_conv1_c_dump_reader;

    localparam int M   = 10;
    localparam int N   = 4;
    localparam int AW  = 6;
    localparam int TOT = M * N;

    typedef struct packed {
        logic signed [31:0] data;
        logic [5:0]         co;
        logic [11:0]        pix;
        logic               last;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic done;

    conv1_c_dump_reader_if #(.ACC_W(32), .ADDR_W(AW)) bus ();

    conv1_c_dump_reader #(
        .M_TOTAL(M), .N_TOTAL(N), .ACC_W_P(32), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .bus(bus.master)
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    offset = 0;
    int    beats = 0;
    int    doneCount = 0;
    int    lastBeatCyc = -10;
    int    issued = 0;
    int    accepted = 0;
    logic  prevStall = 1'b0;
    beat_t prevBeat;
    beat_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model: one-cycle read latency, and word a holds a + offset.
    always @(posedge clk) begin
        bus.rd_valid <= bus.rd_en;
        bus.rd_data  <= 32'(int'(bus.rd_addr) + offset);
    end

    // Monitor: scoreboard pops, stall stability, occupancy bound, done timing.
    always @(negedge clk) begin
        beat_t got;
        beat_t exp;
        got = {bus.m_data, bus.m_co, bus.m_pix, bus.m_last};
        if (rst) begin
            issued    = 0;
            accepted  = 0;
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                total++;
                if (got !== prevBeat) begin
                    bad++;
                    $display("[TB] FAIL stall_stable: got d=%0d co=%0d pix=%0d last=%0b want d=%0d co=%0d pix=%0d last=%0b",
                             got.data, got.co, got.pix, got.last, prevBeat.data, prevBeat.co, prevBeat.pix, prevBeat.last);
                end
            end
            if (bus.rd_en) issued++;
            if (bus.m_valid && bus.m_ready) begin
                accepted++;
                beats++;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL beat: unexpected beat co=%0d pix=%0d, want none", got.co, got.pix);
                end else begin
                    exp = sb.pop_front();
                    if (got !== exp) begin
                        bad++;
                        $display("[TB] FAIL beat: got d=%0d co=%0d pix=%0d last=%0b want d=%0d co=%0d pix=%0d last=%0b",
                                 got.data, got.co, got.pix, got.last, exp.data, exp.co, exp.pix, exp.last);
                    end
                end
                if (bus.m_last) lastBeatCyc = cyc;
            end
            if (issued - accepted > 2) begin
                total++;
                bad++;
                $display("[TB] FAIL occupancy: got %0d outstanding want <=2", issued - accepted);
            end
            if (done) begin
                doneCount++;
                total++;
                if (cyc !== lastBeatCyc + 1) begin
                    bad++;
                    $display("[TB] FAIL done_timing: got cycle %0d want %0d", cyc, lastBeatCyc + 1);
                end
            end
            prevStall = bus.m_valid && !bus.m_ready;
            prevBeat  = got;
        end
    end

    // Push the full expected dump for the current offset.
    task automatic pushDump();
        beat_t b;
        for (int k = 0; k < TOT; k++) begin
            b.co   = 6'(k / M);
            b.pix  = 12'(k % M);
            b.data = 32'((k % M) * N + k / M + offset);
            b.last = (k == TOT - 1);
            sb.push_back(b);
        end
    endtask

    task automatic pulseStart();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        bus.m_ready = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, bus.rd_en, bus.m_valid, bus.m_last} !== 5'b0) begin
            bad++;
            $display("[TB] FAIL reset_ctrl: got %b want 00000", {busy, done, bus.rd_en, bus.m_valid, bus.m_last});
        end
        total++;
        if ({bus.rd_addr, bus.m_data, bus.m_co, bus.m_pix} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_data: got addr=%0d d=%0d co=%0d pix=%0d want all 0",
                     bus.rd_addr, bus.m_data, bus.m_co, bus.m_pix);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_full_dump();
        int lat;
        int gaps;
        $display("[TB] full dump, ready held high");
        bus.m_ready = 1'b1;
        beats = 0;
        doneCount = 0;
        pushDump();
        pulseStart();
        lat = 0;
        gaps = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.m_valid && lat < 10);
        total++;
        if (lat !== 3) begin
            bad++;
            $display("[TB] FAIL latency: got %0d want 3", lat);
        end
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL busy_run: got %b want 1", busy);
        end
        for (int i = 0; i < TOT; i++) begin
            if (!bus.m_valid) gaps++;
            if (i < TOT - 1) @(negedge clk);
        end
        total++;
        if (gaps !== 0 || bus.m_last !== 1'b1) begin
            bad++;
            $display("[TB] FAIL continuous: got gaps=%0d last=%b want gaps=0 last=1", gaps, bus.m_last);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("[TB] FAIL done_pulse: got %b want 1", done);
        end
        @(negedge clk);
        total++;
        if ({done, busy} !== 2'b00 || beats !== TOT || sb.size() !== 0) begin
            bad++;
            $display("[TB] FAIL full_end: got done=%b busy=%b beats=%0d left=%0d want 0 0 %0d 0",
                     done, busy, beats, sb.size(), TOT);
        end
    endtask

    task automatic test_random_ready();
        $display("[TB] random ready, negative data");
        offset = -1000;
        beats = 0;
        doneCount = 0;
        pushDump();
        pulseStart();
        for (int i = 0; i < 2000 && doneCount == 0; i++) begin
            @(posedge clk);
            #1 bus.m_ready = 1'($urandom_range(0, 1));
        end
        #1 bus.m_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (doneCount !== 1 || beats !== TOT || sb.size() !== 0) begin
            bad++;
            $display("[TB] FAIL random_end: got done=%0d beats=%0d left=%0d want 1 %0d 0",
                     doneCount, beats, sb.size(), TOT);
        end
        offset = 0;
    endtask

    task automatic test_stall();
        int reads;
        $display("[TB] ready held low after start");
        bus.m_ready = 1'b0;
        beats = 0;
        doneCount = 0;
        reads = 0;
        pushDump();
        pulseStart();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rd_en) reads++;
        end
        total++;
        if (reads !== 2) begin
            bad++;
            $display("[TB] FAIL stall_reads: got %0d want 2", reads);
        end
        @(posedge clk);
        #1 bus.m_ready = 1'b1;
        for (int i = 0; i < 200 && doneCount == 0; i++) @(negedge clk);
        total++;
        if (doneCount !== 1 || beats !== TOT || sb.size() !== 0) begin
            bad++;
            $display("[TB] FAIL stall_end: got done=%0d beats=%0d left=%0d want 1 %0d 0",
                     doneCount, beats, sb.size(), TOT);
        end
    endtask

    task automatic test_back_to_back();
        $display("[TB] start pulsed while busy");
        bus.m_ready = 1'b1;
        beats = 0;
        doneCount = 0;
        pushDump();
        pulseStart();
        for (int i = 0; i < 200 && beats < 15; i++) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL busy_mid: got %b want 1", busy);
        end
        pulseStart();
        for (int i = 0; i < 200 && doneCount == 0; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        total++;
        if (doneCount !== 1 || beats !== TOT || busy !== 1'b0 || sb.size() !== 0) begin
            bad++;
            $display("[TB] FAIL ignore_start: got done=%0d beats=%0d busy=%b left=%0d want 1 %0d 0 0",
                     doneCount, beats, busy, sb.size(), TOT);
        end
    endtask

    task automatic test_abort();
        $display("[TB] reset mid-dump then restart");
        bus.m_ready = 1'b1;
        beats = 0;
        doneCount = 0;
        pushDump();
        pulseStart();
        for (int i = 0; i < 200 && beats < 20; i++) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++;
            if ({busy, done, bus.rd_en, bus.m_valid, bus.m_last, bus.rd_addr, bus.m_data, bus.m_co, bus.m_pix} !== '0) begin
                bad++;
                $display("[TB] FAIL abort_outputs: got busy=%b done=%b rd_en=%b valid=%b addr=%0d d=%0d co=%0d pix=%0d want all 0",
                         busy, done, bus.rd_en, bus.m_valid, bus.rd_addr, bus.m_data, bus.m_co, bus.m_pix);
            end
            if (c == 0) @(posedge clk);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        repeat (5) @(negedge clk);
        total++;
        if (doneCount !== 0 || bus.m_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL abort_quiet: got done=%0d valid=%b want 0 0", doneCount, bus.m_valid);
        end
        beats = 0;
        pushDump();
        pulseStart();
        for (int i = 0; i < 200 && doneCount == 0; i++) @(negedge clk);
        @(negedge clk);
        total++;
        if (doneCount !== 1 || beats !== TOT || sb.size() !== 0) begin
            bad++;
            $display("[TB] FAIL restart_end: got done=%0d beats=%0d left=%0d want 1 %0d 0",
                     doneCount, beats, sb.size(), TOT);
        end
    endtask

    initial begin
        test_reset();
        test_full_dump();
        test_random_ready();
        test_stall();
        test_back_to_back();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv1_c_dump_reader.md
CONV1_C_DUMP_READER -- requirements
Module: conv1_c_dump_reader

Interface
REQ-001 Parameter M_TOTAL, default 3136: number of output pixels, equal to H_OUT*W_OUT = 56*56.
REQ-002 Parameter N_TOTAL, default 64: number of output channels (COUT).
REQ-003 Parameter ACC_W_P, default ACC_W from backbone_pkg: accumulator word width.
REQ-004 Parameter ADDR_W, default 18: BRAM address width, which SHALL satisfy 2^ADDR_W >= M_TOTAL*N_TOTAL.
REQ-005 Port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-006 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 Port start, input, 1 bit: one-cycle request to begin a full dump.
REQ-008 Port busy, output, 1 bit: high from the cycle after start is accepted until the done pulse.
REQ-009 Port done, output, 1 bit: one-cycle pulse after the final beat is accepted.
REQ-010 Port rd_en, output, 1 bit: C accumulator BRAM read request.
REQ-011 Port rd_addr, output, ADDR_W bits: BRAM word address, equal to m*N_TOTAL + n.
REQ-012 Port rd_data, input, ACC_W_P bits, signed: BRAM read data.
REQ-013 Port rd_valid, input, 1 bit: rd_data is valid; it arrives exactly 1 cycle after rd_en.
REQ-014 Port m_valid, output, 1 bit: stream beat valid.
REQ-015 Port m_ready, input, 1 bit: downstream accept.
REQ-016 Port m_data, output, ACC_W_P bits, signed: output value out[co][oh][ow].
REQ-017 Port m_co, output, 6 bits: channel index of the current beat.
REQ-018 Port m_pix, output, 12 bits: pixel index m = oh*56 + ow of the current beat.
REQ-019 Port m_last, output, 1 bit: high on the beat with co = N_TOTAL-1 and m = M_TOTAL-1.

Function
REQ-020 The read order SHALL be channel-major: the outer loop is co from 0 to N_TOTAL-1, the inner loop is m from 0 to M_TOTAL-1, and rd_addr = m*N_TOTAL + co.
REQ-021 The address SHALL be computed incrementally, with no multiplier:
- rd_addr += N_TOTAL on each pixel step;
- when m wraps to 0, rd_addr is set to co+1.
REQ-022 The FSM SHALL have four states: IDLE, RUN, DRAIN and FIN.
REQ-023 In IDLE, start=1 SHALL move the FSM to RUN and clear the m, co and beat counters.
REQ-024 In RUN, reads SHALL be issued until the read at (co=N_TOTAL-1, m=M_TOTAL-1) is issued, after which the FSM moves to DRAIN.
REQ-025 In DRAIN, no reads SHALL be issued; the FSM moves to FIN when the beat with m_last=1 is accepted.
REQ-026 FIN SHALL assert done for exactly one cycle and then return to IDLE.
REQ-027 start SHALL be ignored in every state other than IDLE.
REQ-028 Returning data SHALL be buffered in a 2-entry output FIFO.
REQ-029 rd_en SHALL be asserted only when (FIFO occupancy + reads in flight) < 2, so no read data is ever dropped.
REQ-030 Each FIFO entry SHALL hold {data, co, pix, last}; these tags are captured at issue time and carried through the in-flight register.
REQ-031 A beat transfers when m_valid=1 and m_ready=1.
REQ-032 m_valid SHALL equal (FIFO not empty).
REQ-033 m_data, m_co, m_pix and m_last SHALL stay stable while m_valid=1 and m_ready=0.
REQ-034 A FIFO push and pop in the same cycle SHALL leave occupancy unchanged and preserve order.
REQ-035 When the FIFO is full and m_ready=1, a read SHALL still be issued that cycle, so steady-state throughput is 1 beat per cycle.
REQ-036 A rd_valid with no read in flight SHALL be ignored.
REQ-037 Data SHALL pass through unmodified: no truncation, saturation or sign change.
REQ-038 Total beats per dump SHALL be exactly M_TOTAL*N_TOTAL = 200704.
REQ-039 Latency from the start cycle to the first m_valid SHALL be 3 cycles (start accept, read issue, FIFO push).

Reset
REQ-040 While rst=1, the FSM SHALL be in IDLE and the FIFO and all counters SHALL be cleared.
REQ-041 While rst=1, the outputs SHALL be: busy=0, done=0, rd_en=0, rd_addr=0, m_valid=0, m_last=0, m_data=0, m_co=0, m_pix=0.
REQ-042 Reset asserted mid-dump SHALL abort the dump immediately and discard in-flight data, with no done pulse.
REQ-043 A later start after such a reset SHALL restart the dump from co=0, m=0.

Verification
REQ-044 Preload BRAM word a with value a, hold m_ready=1, pulse start:
- the response SHALL be 200704 beats;
- beat k has m_co = k/3136, m_pix = k%3136 and m_data = m_pix*64 + m_co;
- m_last is high only on beat 200703;
- done pulses 1 cycle after that beat.
REQ-045 With m_ready=1 held throughout, m_valid SHALL be continuously high from the first beat to the last, so the run takes 200704 cycles plus 3 cycles of latency.
REQ-046 With m_ready driven by a random 50% pattern:
- the beat sequence SHALL be identical to REQ-044;
- there are no drops or duplicates;
- outputs are stable during stalls;
- FIFO occupancy never exceeds 2.
REQ-047 Hold m_ready=0 for 20 cycles after start, then release it:
- exactly 2 reads are issued in total during the stall;
- the beats (co=0, m=0) and (co=0, m=1) emerge first after release.
REQ-048 Pulse start again while busy=1 at beat 1000: the pulse SHALL be ignored, and the beat count and done timing SHALL match REQ-044.
REQ-049 Assert rst for 2 cycles at beat 5000, then pulse start:
- outputs are 0 during rst;
- there is no done pulse for the aborted dump;
- the new dump begins at m_co=0, m_pix=0 and completes normally.
